spectrum_smoother: RTL and testbench

- Sits between the FFT magnitude output and the graphics controller.
- On each completed FFT frame it walks all N bins serially, one bin per clock, and scales and saturates each magnitude to a bar height.
- It applies instant-attack / proportional-decay smoothing and maintains a per-bin peak-hold marker with timed falloff.
- Outputs are stable register arrays that the graphics controller reads asynchronously to its own frame timing.

---
 rtl/spectrum_smoother.sv | 148 ++++++++++++++
 tb/tb_spectrum_smoother.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_smoother.sv
// Per-frame spectrum bar smoother: walks all bins serially after each FFT frame,
// scaling/saturating magnitudes into bar heights with decay smoothing and peak-hold markers.
module spectrum_smoother #(
  parameter int N           = 256,
  parameter int WIDTH       = 19,
  parameter int OUT_W       = 10,
  parameter int SHIFT       = 6,
  parameter int DECAY_SHIFT = 3,
  parameter int HOLD_FRAMES = 30,
  parameter int PEAK_FALL   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fft_done,
  input  logic             freeze,
  input  logic [WIDTH:0]   freq_mag [N],
  output logic [OUT_W-1:0] bar      [N],
  output logic [OUT_W-1:0] peak     [N],
  output logic             busy,
  output logic             frame_valid
);

  localparam int IDX_W   = $clog2(N);
  localparam int HOLD_W  = $clog2(HOLD_FRAMES + 1);
  localparam int MAX_BAR = (1 << OUT_W) - 1;

  typedef enum logic {IDLE, PROCESS} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             prev_reg;
  logic             frame_valid_reg, frame_valid_next;
  logic             write_en;
  logic [N-1:0]     bin_we;

  logic [OUT_W-1:0]  bar_reg  [N];
  logic [OUT_W-1:0]  peak_reg [N];
  logic [HOLD_W-1:0] hold_reg [N];

  logic [WIDTH:0]    scaled;
  logic [OUT_W-1:0]  target, cur_bar, cur_peak, diff, decay, fallen;
  logic [OUT_W-1:0]  bar_next, peak_next;
  logic [HOLD_W-1:0] cur_hold, hold_next;

  // Bin datapath: operates on the bin currently selected by idx_reg.
  always_comb begin
    cur_bar  = bar_reg[idx_reg];
    cur_peak = peak_reg[idx_reg];
    cur_hold = hold_reg[idx_reg];
    scaled   = freq_mag[idx_reg] >> SHIFT;
    target   = (scaled > (WIDTH+1)'(MAX_BAR)) ? OUT_W'(MAX_BAR) : scaled[OUT_W-1:0];
    diff     = cur_bar - target;
    decay    = diff >> DECAY_SHIFT;
    fallen   = (cur_peak > OUT_W'(PEAK_FALL)) ? cur_peak - OUT_W'(PEAK_FALL) : '0;

    if (target >= cur_bar)
      bar_next = target;
    else if (decay != '0)
      bar_next = cur_bar - decay;
    else
      bar_next = cur_bar - OUT_W'(1);

    if (bar_next >= cur_peak) begin
      peak_next = bar_next;
      hold_next = HOLD_W'(HOLD_FRAMES);
    end else if (cur_hold != '0) begin
      peak_next = cur_peak;
      hold_next = cur_hold - HOLD_W'(1);
    end else begin
      peak_next = (fallen > bar_next) ? fallen : bar_next;
      hold_next = cur_hold;
    end
  end

  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    frame_valid_next = 1'b0;
    write_en         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fft_done && !prev_reg && !freeze) begin
          state_next = PROCESS;
          idx_next   = '0;
        end
      end
      PROCESS: begin
        if (!fft_done) begin
          // Frame abandoned; bins already written keep their new values.
          state_next = IDLE;
        end else begin
          write_en = 1'b1;
          if (idx_reg == IDX_W'(N - 1)) begin
            state_next       = IDLE;
            frame_valid_next = 1'b1;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      prev_reg        <= 1'b0;
      frame_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      prev_reg        <= fft_done;
      frame_valid_reg <= frame_valid_next;
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_we
      assign bin_we[gi] = write_en && (idx_reg == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        bar_reg[i]  <= '0;
        peak_reg[i] <= '0;
        hold_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bin_we[i]) begin
          bar_reg[i]  <= bar_next;
          peak_reg[i] <= peak_next;
          hold_reg[i] <= hold_next;
        end
      end
    end
  end

  assign bar         = bar_reg;
  assign peak        = peak_reg;
  assign busy        = (state_reg == PROCESS);
  assign frame_valid = frame_valid_reg;

endmodule

// File: tb/tb_spectrum_smoother.sv
// Bench for spectrum_smoother (N=16): directed frame table, hold/falloff and abort/reset
// sequences, then randomized frames checked cycle by cycle against a per-bin arithmetic model.
module tb_spectrum_smoother;
  localparam int N     = 16;
  localparam int WIDTH = 19;
  localparam int OUT_W = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             fft_done = 1'b0;
  logic             freeze = 1'b0;
  logic [WIDTH:0]   mag  [N];
  logic [OUT_W-1:0] bar  [N];
  logic [OUT_W-1:0] peak [N];
  logic             busy, frame_valid;

  int checks = 0;
  int errors = 0;
  int frames = 0;
  int m_bar[N], m_peak[N], m_hold[N];
  int o_bar[N], o_peak[N], o_hold[N];

  typedef struct {
    bit rst_first;
    bit frz;
    int mag;
    int exp_bar;
    int exp_peak;
  } vec_t;
  vec_t tbl[11];

  spectrum_smoother #(.N(N)) dut (
    .clk(clk), .rst(rst), .fft_done(fft_done), .freeze(freeze),
    .freq_mag(mag), .bar(bar), .peak(peak), .busy(busy), .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int j = 0; j < N; j++) begin
      m_bar[j] = 0; m_peak[j] = 0; m_hold[j] = 0;
      o_bar[j] = 0; o_peak[j] = 0; o_hold[j] = 0;
    end
  endfunction

  // Frame rule for one bin, straight from the arithmetic definition.
  function automatic void model_bin(input int i, input int mg);
    int t, b, nb, d, p;
    b = m_bar[i];
    p = m_peak[i];
    t = mg / 64;
    if (t > 1023) t = 1023;
    if (t >= b) nb = t;
    else begin
      d  = (b - t) / 8;
      nb = (d != 0) ? b - d : b - 1;
    end
    if (nb >= p) begin
      p = nb;
      m_hold[i] = 30;
    end else if (m_hold[i] != 0) begin
      m_hold[i] = m_hold[i] - 1;
    end else begin
      p = p - 4;
      if (p < 0) p = 0;
      if (p < nb) p = nb;
    end
    m_bar[i]  = nb;
    m_peak[i] = p;
  endfunction

  task automatic chk_bins(input string tag, input int upto);
    for (int j = 0; j < N; j++) begin
      chk($sformatf("%s_bar[%0d]", tag, j),  int'(bar[j]),  (j <= upto) ? m_bar[j]  : o_bar[j]);
      chk($sformatf("%s_peak[%0d]", tag, j), int'(peak[j]), (j <= upto) ? m_peak[j] : o_peak[j]);
    end
  endtask

  task automatic set_all(input int v);
    for (int j = 0; j < N; j++) mag[j] = (WIDTH+1)'(v);
  endtask

  task automatic do_reset();
    rst = 1'b0; fft_done = 1'b0; freeze = 1'b0;
    step();
    model_reset();
    rst = 1'b1;
    step();
  endtask

  task automatic run_frame(input bit frz, input int abort_at);
    for (int j = 0; j < N; j++) begin
      o_bar[j] = m_bar[j]; o_peak[j] = m_peak[j]; o_hold[j] = m_hold[j];
    end
    if (!frz)
      for (int j = 0; j < N; j++) model_bin(j, int'(mag[j]));
    fft_done = 1'b0; freeze = frz;
    step();
    fft_done = 1'b1;
    step();
    chk("busy_after_start", int'(busy), frz ? 0 : 1);
    chk("fv_after_start", int'(frame_valid), 0);
    if (frz) begin
      for (int c = 0; c <= N; c++) begin
        step();
        chk("busy_frozen", int'(busy), 0);
        chk("fv_frozen", int'(frame_valid), 0);
      end
      chk_bins("frozen", -1);
    end else begin
      for (int i = 0; i < N; i++) begin
        step();
        chk_bins("wr", i);
        chk($sformatf("busy_bin%0d", i), int'(busy), (i < N - 1) ? 1 : 0);
        chk($sformatf("fv_bin%0d", i), int'(frame_valid), (i == N - 1) ? 1 : 0);
        if (i == abort_at) begin
          fft_done = 1'b0;
          step();
          chk("busy_abort", int'(busy), 0);
          chk("fv_abort", int'(frame_valid), 0);
          chk_bins("abort", i);
          for (int j = i + 1; j < N; j++) begin
            m_bar[j] = o_bar[j]; m_peak[j] = o_peak[j]; m_hold[j] = o_hold[j];
          end
          break;
        end
      end
    end
    fft_done = 1'b0; freeze = 1'b0;
    step();
    chk("fv_after_frame", int'(frame_valid), 0);
    chk("busy_after_frame", int'(busy), 0);
    frames++;
    $display("frame %0d freeze=%0d abort_at=%0d bar0=%0d peak0=%0d barN=%0d peakN=%0d",
             frames, frz, abort_at, bar[0], peak[0], bar[N-1], peak[N-1]);
  endtask

  initial begin
    tbl[0]  = '{0, 0, 16384,    256,  256};
    tbl[1]  = '{0, 0, 0,        224,  256};
    tbl[2]  = '{0, 0, 'hFFFFF,  1023, 1023};
    tbl[3]  = '{0, 1, 0,        1023, 1023};
    tbl[4]  = '{1, 0, 320,      5,    5};
    tbl[5]  = '{0, 0, 0,        4,    5};
    tbl[6]  = '{0, 0, 0,        3,    5};
    tbl[7]  = '{0, 0, 0,        2,    5};
    tbl[8]  = '{0, 0, 0,        1,    5};
    tbl[9]  = '{0, 0, 0,        0,    5};
    tbl[10] = '{0, 0, 0,        0,    5};

    set_all(0);
    model_reset();
    repeat (2) step();
    chk("reset_busy", int'(busy), 0);
    chk("reset_fv", int'(frame_valid), 0);
    chk_bins("reset", -1);
    rst = 1'b1;
    step();

    for (int r = 0; r < 11; r++) begin
      if (tbl[r].rst_first) do_reset();
      set_all(tbl[r].mag);
      run_frame(tbl[r].frz, -1);
      for (int j = 0; j < N; j++) begin
        chk($sformatf("tbl%0d_bar[%0d]", r, j), int'(bar[j]), tbl[r].exp_bar);
        chk($sformatf("tbl%0d_peak[%0d]", r, j), int'(peak[j]), tbl[r].exp_peak);
      end
    end

    // Peak hold of 30 frames, then falls by 4 per frame.
    do_reset();
    set_all(6400);
    run_frame(0, -1);
    chk("hold_set_peak", int'(peak[0]), 100);
    set_all(640);
    for (int f = 1; f <= 32; f++) begin
      run_frame(0, -1);
      if (f == 30) chk("hold_last", int'(peak[3]), 100);
      if (f == 31) chk("fall_1", int'(peak[3]), 96);
      if (f == 32) chk("fall_2", int'(peak[3]), 92);
    end

    // Abort after bin 7 is written.
    begin
      int kept8;
      kept8 = m_bar[8];
      set_all(16384);
      run_frame(0, 7);
      chk("abort_bin7", int'(bar[7]), 256);
      chk("abort_bin8_kept", int'(bar[8]), kept8);
    end

    // Reset asserted mid-frame clears outputs before the next clock edge.
    do_reset();
    set_all(16384);
    fft_done = 1'b0;
    step();
    fft_done = 1'b1;
    step();
    repeat (4) step();
    chk("pre_rst_bar0", int'(bar[0]), 256);
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b0;
    #1;
    model_reset();
    chk_bins("async_rst", -1);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_fv", int'(frame_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    fft_done = 1'b0;
    step();
    chk("post_rst_fv", int'(frame_valid), 0);

    // Randomized frames against the model.
    do_reset();
    for (int f = 0; f < 45; f++) begin
      bit frz;
      int ab;
      for (int j = 0; j < N; j++) begin
        if ($urandom_range(0, 7) == 0) mag[j] = (WIDTH+1)'($urandom_range(0, 'hFFFFF));
        else                           mag[j] = (WIDTH+1)'($urandom_range(0, 'h10000));
      end
      frz = ($urandom_range(0, 9) == 0);
      ab  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, N - 2)) : -1;
      run_frame(frz, ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
